// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch arbiter.
// Every block that touches fetch state or port ids imports this package.
package imem_fetch_pkg;

    localparam int BYTE_W = 8;
    localparam int BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        RESP
    } state_t;

    typedef logic port_id_t;

endpackage

// File: rtl/imem_fetch_arbiter_rr_arb2.sv
// Two-request round-robin arbiter. On a tie, the port that did not win last time
// gets the grant. The history bit only advances when a grant actually happens.
module rr_arb2
    import imem_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt,
    output port_id_t   gnt_id
);

    port_id_t last;

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (grant_en && (req != 2'b00)) begin
            gnt_id = (req == 2'b11) ? ~last : req[1];
            gnt    = gnt_id ? 2'b10 : 2'b01;
        end
    end

    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (grant_en && (req != 2'b00)) begin
            last <= gnt_id;
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one byte-wide synchronous ROM port between two requesters. Each transaction
// reads four bytes and returns one big-endian 32-bit word to the port that was granted.
module imem_fetch_arbiter
    import imem_fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    output logic                     rsp_valid0,
    output logic                     rsp_valid1,
    output logic [DATA_WIDTH-1:0]    rsp_data0,
    output logic [DATA_WIDTH-1:0]    rsp_data1,
    output logic                     busy,
    output logic                     mem_rd,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [BYTE_W-1:0]        mem_rdata
);

    if (DATA_WIDTH != BEATS * BYTE_W) begin : g_width_check
        $error("imem_fetch_arbiter: DATA_WIDTH must be exactly four bytes");
    end

    state_t                   state, state_next;
    logic [2:0]               beat, beat_next;
    logic [ADDRESS_WIDTH-1:0] base, base_next;
    port_id_t                 port, port_next;
    logic [DATA_WIDTH-1:0]    asm_word, asm_next;
    logic                     mem_rd_next, busy_next;
    logic [ADDRESS_WIDTH-1:0] mem_addr_next;
    logic [1:0]               rsp_valid_next;
    logic [DATA_WIDTH-1:0]    rsp_data0_next, rsp_data1_next;
    logic [1:0]               gnt;
    port_id_t                 gnt_id;
    logic                     grant_en;

    assign grant_en = (state == IDLE);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      ({req1, req0}),
        .grant_en (grant_en),
        .gnt      (gnt),
        .gnt_id   (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= 3'd0;
            base       <= '0;
            port       <= 1'b0;
            asm_word   <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_data0  <= '0;
            rsp_data1  <= '0;
        end else begin
            state      <= state_next;
            beat       <= beat_next;
            base       <= base_next;
            port       <= port_next;
            asm_word   <= asm_next;
            mem_rd     <= mem_rd_next;
            mem_addr   <= mem_addr_next;
            busy       <= busy_next;
            rsp_valid0 <= rsp_valid_next[0];
            rsp_valid1 <= rsp_valid_next[1];
            rsp_data0  <= rsp_data0_next;
            rsp_data1  <= rsp_data1_next;
        end
    end

    // All outputs are registered, so each state computes what the ROM port and
    // the response registers must show during the following cycle.
    always_comb begin
        state_next     = state;
        beat_next      = beat;
        base_next      = base;
        port_next      = port;
        asm_next       = asm_word;
        mem_rd_next    = 1'b0;
        mem_addr_next  = mem_addr;
        rsp_valid_next = 2'b00;
        rsp_data0_next = rsp_data0;
        rsp_data1_next = rsp_data1;

        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    port_next     = gnt_id;
                    base_next     = gnt_id ? addr1 : addr0;
                    beat_next     = 3'd0;
                    mem_rd_next   = 1'b1;
                    mem_addr_next = gnt_id ? addr1 : addr0;
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                beat_next = beat + 3'd1;
                // Read data lags the read by one cycle, so beat 0 has nothing to capture yet.
                if (beat != 3'd0) begin
                    asm_next = {asm_word[DATA_WIDTH-BYTE_W-1:0], mem_rdata};
                end
                if (beat == 3'(BEATS - 1)) begin
                    state_next = DRAIN;
                end else begin
                    mem_rd_next   = 1'b1;
                    mem_addr_next = base + ADDRESS_WIDTH'(beat + 3'd1);
                end
            end
            DRAIN: begin
                asm_next = {asm_word[DATA_WIDTH-BYTE_W-1:0], mem_rdata};
                rsp_valid_next[port] = 1'b1;
                if (port) begin
                    rsp_data1_next = asm_next;
                end else begin
                    rsp_data0_next = asm_next;
                end
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_next = (state_next != IDLE);

endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Byte-serial fetch controller and two-port arbiter for the byte-wide instruction ROM. Two requesters (port 0: core fetch; port 1: debug/loader read-back) share one synchronous 8-bit read port. The block reads four consecutive bytes and returns one 32-bit big-endian word: the byte at the base address becomes bits 31:24. It sits between the PC/fetch stage and the ROM.

## Interface
- ADDRESS_WIDTH, 16, byte-address width of the ROM and of both request ports
- DATA_WIDTH, 32, response word width; fixed at 4 bytes, any other value is a elaboration error

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from port 0 / 1; level, sampled only in IDLE
- addr0 / addr1  in  ADDRESS_WIDTH  base byte address for port 0 / 1; latched at grant
- rsp_valid0 / rsp_valid1  out  1  one-cycle pulse, response for that port ready
- rsp_data0 / rsp_data1  out  DATA_WIDTH  assembled word; holds until next response to same port
- busy  out  1  high whenever state is not IDLE
- mem_rd  out  1  ROM read enable
- mem_addr  out  ADDRESS_WIDTH  ROM byte address
- mem_rdata  in  8  ROM read data; valid the cycle after mem_rd (1-cycle sync read)

## Operation
- States: IDLE, FETCH, DRAIN, RESP. A 3-bit beat counter `beat` (0..4) runs in FETCH/DRAIN.
- IDLE: if any req is high, grant one port. Latch its port id and addr into `base`, clear `beat`, go to FETCH. If no req, stay.
- Arbitration is round-robin on a 1-bit `last` register:
  - Single requester wins immediately.
  - If both request, the port != `last` wins.
  - `last` updates to the winner at grant. Reset value of `last` = 1, so port 0 wins the first tie.
- FETCH: mem_rd=1, mem_addr = base + beat, computed modulo 2^ADDRESS_WIDTH (wraps 0xFFFF→0x0000 at default width). `beat` increments each cycle. After beat 3 is issued, go to DRAIN.
- Byte capture: each cycle after an issued read, shift mem_rdata into a 32-bit assembly register, MSB-first: {asm[23:0], mem_rdata}. Four captures put byte@base in [31:24] and byte@base+3 in [7:0].
- DRAIN: mem_rd=0. Capture the final byte, then go to RESP.
- RESP:
  - Copy the assembly register into rsp_data of the granted port.
  - Pulse that port's rsp_valid for exactly one cycle.
  - The other port's outputs are unchanged.
  - Go to IDLE.
- req dropped mid-transaction: the transaction still completes and the response still pulses.
- addr changes after grant are ignored.
- No alignment check; any base address is legal.
- A requester that keeps req high after rsp_valid issues a new request, sampled in the next IDLE cycle.
- mem_rd is never high outside FETCH.

## Timing
- Reset (async assert, any state) forces:
  - state = IDLE, beat = 0, last = 1
  - mem_rd = 0, mem_addr = 0, busy = 0
  - rsp_valid0/1 = 0, rsp_data0/1 = 0, assembly register = 0
- An aborted transaction never produces a response. A request still held high after reset release is re-arbitrated from IDLE.
- Cycle plan, with edge E0 sampling req in IDLE:
  - cycles 1–4: mem_rd high, addr base..base+3
  - edges E2–E5: byte captures
  - cycle 5: DRAIN
  - cycle 6: rsp_valid high (RESP)
  - cycle 7: IDLE
- Latency from the sampling edge to rsp_valid is 6 cycles. Maximum throughput is one word per 7 cycles.
- busy is high in cycles 1–6.
- Outputs are registered: rsp_valid, rsp_data, mem_rd, mem_addr and busy come straight from flops.

## Structure
- Package imem_fetch_pkg holds:
  - state enum typedef (IDLE, FETCH, DRAIN, RESP)
  - constants BYTE_W = 8 and BEATS = 4
  - port-id typedef (1 bit)
- Sub-module rr_arb2: two-request round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], grant_en.
  - Outputs: gnt[1:0] (one-hot or zero), gnt_id.
  - Owns `last`.
- FSM, counter, address adder and assembly shift register live in imem_fetch_arbiter.

## Test plan
- Single fetch: ROM[0x0010..0x0013] = 0x13,0x05,0x00,0x00; req0 with addr0=0x0010 → rsp_valid0 pulses 6 cycles after the sampling edge, rsp_data0 = 0x13050000; rsp_valid1 stays 0; exactly four mem_rd cycles at 0x0010..0x0013.
- Tie then alternate: req0 and req1 held high from reset, addr0=0x0000, addr1=0x0100 → responses go to port 0, 1, 0, 1, 7 cycles apart; each rsp_data matches its ROM word.
- Wrap-around: addr0=0xFFFE, ROM[0xFFFE]=0xAA, ROM[0xFFFF]=0xBB, ROM[0x0000]=0xCC, ROM[0x0001]=0xDD → mem_addr sequence FFFE, FFFF, 0000, 0001; rsp_data0 = 0xAABBCCDD.
- Request/address churn: addr0 changed to 0x0200 and req0 dropped in cycle 2 of a transaction at 0x0010 → response still pulses with the 0x0010 word; no second transaction starts.
- Reset mid-operation: assert rst_n=0 in cycle 3 of a fetch → all outputs 0 within the same cycle, no rsp_valid; release with req1 high → fresh transaction for port 1 with full 6-cycle latency; rsp_data1 correct.
